// File: rtl/lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : lane_packer
// Description : Packs a stream of narrow lanes into one wide word of
//               PAR_LANES lanes. A word closes when its top lane is written
//               or when an incoming lane carries ib_last. The closed word is
//               registered one cycle later with a per-lane valid mask. Lanes
//               that were never written read as zero.
//
// Parameters  : PAR_DATA_BITS  width of one lane
//               PAR_LANES      lanes per packed word (legal range 2..16)
//
// Ports       : ib_clk       clock, all state on its rising edge
//               ib_rst       asynchronous reset, active low
//               ivG_data     incoming lane word
//               ib_valid     ivG_data / ib_last are valid
//               ib_last      this lane closes the current word early
//               ib_ready     a lane is accepted this cycle when ib_valid=1
//               ovG_data     packed output word (lane i at [i*W +: W])
//               ovG_lane_en  bit i set = lane i of ovG_data holds data
//               ob_last      word was closed by ib_last
//               ob_valid     output word is valid
//               ob_ready     downstream accepts the output word
//               ovG_words    count of drained words, wraps at 16 bits
//
// Revision    : 1.0  initial release
// ============================================================================
module lane_packer #(
    parameter int PAR_DATA_BITS = 16,
    parameter int PAR_LANES     = 4
) (
    input  logic                               ib_clk,
    input  logic                               ib_rst,
    input  logic [PAR_DATA_BITS-1:0]           ivG_data,
    input  logic                               ib_valid,
    input  logic                               ib_last,
    output logic                               ib_ready,
    output logic [PAR_DATA_BITS*PAR_LANES-1:0] ovG_data,
    output logic [PAR_LANES-1:0]               ovG_lane_en,
    output logic                               ob_last,
    output logic                               ob_valid,
    input  logic                               ob_ready,
    output logic [15:0]                        ovG_words
);

    localparam int                 IDX_W    = $clog2(PAR_LANES);
    localparam int                 WORD_W   = PAR_DATA_BITS * PAR_LANES;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(PAR_LANES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0]     idx_q,       idx_d;
    logic [WORD_W-1:0]    asm_data_q,  asm_data_d;
    logic [PAR_LANES-1:0] fill_q,      fill_d;
    logic [WORD_W-1:0]    out_data_q,  out_data_d;
    logic [PAR_LANES-1:0] lane_en_q,   lane_en_d;
    logic                 out_last_q,  out_last_d;
    logic                 out_valid_q, out_valid_d;
    logic [15:0]          words_q,     words_d;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic w_accept;
    logic w_complete;
    logic w_drain;

    // The output register can take a new word whenever it is empty or is
    // being emptied in this very cycle, so streaming has no bubbles.
    assign ib_ready   = !out_valid_q || ob_ready;
    assign w_accept   = ib_valid && ib_ready;
    assign w_complete = w_accept && ((idx_q == LAST_IDX) || ib_last);
    assign w_drain    = out_valid_q && ob_ready;

    // ------------------------------------------------------------------------
    // Per-lane merge of the incoming beat into the assembly image.
    // w_asm_next / w_fill_next describe the assembly as it would look with
    // the current beat included; w_masked is that image with unfilled lanes
    // forced to zero, ready to be loaded into the output register.
    // ------------------------------------------------------------------------
    logic [WORD_W-1:0]    w_asm_next;
    logic [PAR_LANES-1:0] w_fill_next;
    logic [WORD_W-1:0]    w_masked;

    for (genvar gi = 0; gi < PAR_LANES; gi++) begin : g_lane
        logic w_sel;

        assign w_sel = w_accept && (idx_q == IDX_W'(gi));

        assign w_fill_next[gi] = fill_q[gi] || w_sel;

        assign w_asm_next[gi*PAR_DATA_BITS +: PAR_DATA_BITS] =
            w_sel ? ivG_data : asm_data_q[gi*PAR_DATA_BITS +: PAR_DATA_BITS];

        assign w_masked[gi*PAR_DATA_BITS +: PAR_DATA_BITS] =
            w_fill_next[gi] ? w_asm_next[gi*PAR_DATA_BITS +: PAR_DATA_BITS]
                            : {PAR_DATA_BITS{1'b0}};
    end

    // ------------------------------------------------------------------------
    // Assembly side next state
    // ------------------------------------------------------------------------
    always_comb begin
        idx_d      = idx_q;
        asm_data_d = asm_data_q;
        fill_d     = fill_q;

        if (w_complete) begin
            // Word handed to the output register; start a fresh one at lane 0.
            idx_d      = '0;
            asm_data_d = '0;
            fill_d     = '0;
        end else if (w_accept) begin
            idx_d      = idx_q + 1'b1;
            asm_data_d = w_asm_next;
            fill_d     = w_fill_next;
        end
    end

    // ------------------------------------------------------------------------
    // Output side next state
    // ------------------------------------------------------------------------
    always_comb begin
        out_data_d  = out_data_q;
        lane_en_d   = lane_en_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        words_d     = words_q;

        if (w_drain) begin
            words_d     = words_q + 16'd1;
            out_valid_d = 1'b0;
        end

        // A completion can only happen when the register is empty or being
        // drained (ib_ready), so loading here never overwrites a held word.
        if (w_complete) begin
            out_data_d  = w_masked;
            lane_en_d   = w_fill_next;
            out_last_d  = ib_last;
            out_valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge ib_clk or negedge ib_rst) begin
        if (!ib_rst) begin
            idx_q       <= '0;
            asm_data_q  <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            lane_en_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            words_q     <= '0;
        end else begin
            idx_q       <= idx_d;
            asm_data_q  <= asm_data_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            lane_en_q   <= lane_en_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            words_q     <= words_d;
        end
    end

    assign ovG_data    = out_data_q;
    assign ovG_lane_en = lane_en_q;
    assign ob_last     = out_last_q;
    assign ob_valid    = out_valid_q;
    assign ovG_words   = words_q;

endmodule
`default_nettype wire
